sd_wr_feeder: RTL and testbench

Upstream stage of the SD-card SPI sector writer. It accepts a stream of 16-bit words through a valid/ready handshake and packs them into two 256-word (512-byte) banks. Each full bank is issued to the writer as one CMD24 single-block write, with an incrementing sector address. It answers the writer's one-cycle `wr_req` pulses with the next word and hides SD busy time behind filling of the other bank.

---
 rtl/sd_defs_pkg.sv | 26 ++
 rtl/sd_bank_ram.sv | 27 ++
 rtl/sd_wr_feeder.sv | 133 +++++++++++++
 tb/tb_sd_wr_feeder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sd_defs_pkg.sv
// Shared definitions for the SD-card sector write feeder: sizes, drain FSM
// encoding and the bank RAM write payload.
package sd_defs_pkg;

  localparam int unsigned WORDS_PER_SEC = 256;
  localparam int unsigned PTR_W         = 8;
  localparam int unsigned CNT_W         = 9;
  localparam int unsigned DATA_W        = 16;
  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned RAM_AW        = PTR_W + 1;

  localparam logic [DATA_W-1:0] PAD_WORD = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_START    = 2'd1,
    ST_XFER     = 2'd2,
    ST_WAIT_END = 2'd3
  } drain_state_e;

  typedef struct packed {
    logic [RAM_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } ram_wr_t;

endpackage

// File: rtl/sd_bank_ram.sv
// Two 256-word sector banks in one 512x16 simple dual-port RAM; the
// registered read port doubles as the word register handed to the writer.
module sd_bank_ram
  import sd_defs_pkg::*;
(
  input  logic              clk_ref,
  input  logic              rst,
  input  logic              we,
  input  ram_wr_t           wr,
  input  logic              re,
  input  logic [RAM_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2*WORDS_PER_SEC];

  always_ff @(posedge clk_ref) begin
    if (we) mem[wr.addr] <= wr.data;
  end

  // Read register resets so the writer sees zero until the first served word.
  always_ff @(posedge clk_ref) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sd_wr_feeder.sv
// Packs a 16-bit upstream stream into two sector banks and issues each full
// bank as one single-block write. Optional flush/pad: SD_WR_FEEDER_FLUSH_EN.
module sd_wr_feeder
  import sd_defs_pkg::*;
#(
  parameter logic [31:0] START_SECTOR = 32'd0,
  parameter logic [31:0] SECTOR_COUNT = 32'd0
) (
  input  logic              clk_ref,
  input  logic              rst,
`ifdef SD_WR_FEEDER_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_start_en,
  output logic [ADDR_W-1:0] wr_sec_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_req,
  input  logic              wr_busy,
  output logic              sec_done,
  output logic              all_done,
  output logic              err_ovr
);

  drain_state_e      state;
  logic [1:0]        full;
  logic              fill_bank;
  logic              drain_bank;
  logic [PTR_W-1:0]  fill_ptr;
  logic [CNT_W-1:0]  rd_cnt;
  logic [ADDR_W-1:0] sec_cnt;
  logic              padding;
  logic              fill_we;
  logic              fill_last;
  logic              rd_en;
  logic              rd_spent;
  ram_wr_t           fill_wr;

  assign in_ready  = !rst && !full[fill_bank] && !all_done && !padding;
  assign fill_we   = (in_valid && in_ready) || (padding && !rst);
  assign fill_last = fill_we && (fill_ptr == PTR_W'(WORDS_PER_SEC - 1));
  assign fill_wr   = ram_wr_t'{addr: {fill_bank, fill_ptr},
                               data: padding ? PAD_WORD : in_data};
  assign rd_spent  = (rd_cnt == CNT_W'(WORDS_PER_SEC));
  assign rd_en     = (state == ST_XFER) && wr_req && !rd_spent;

`ifdef SD_WR_FEEDER_FLUSH_EN
  // Pad a partial bank with zeros until it completes.
  always_ff @(posedge clk_ref) begin
    if (rst)                                           padding <= 1'b0;
    else if (fill_last)                                padding <= 1'b0;
    else if (flush && (fill_ptr != '0) && !all_done)   padding <= 1'b1;
  end
`else
  assign padding = 1'b0;
`endif

  // Fill pointer/bank tracking and the drain FSM share the full flags.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state       <= ST_IDLE;
      full        <= '0;
      fill_bank   <= 1'b0;
      drain_bank  <= 1'b0;
      fill_ptr    <= '0;
      rd_cnt      <= '0;
      sec_cnt     <= '0;
      wr_start_en <= 1'b0;
      wr_sec_addr <= START_SECTOR;
      sec_done    <= 1'b0;
      all_done    <= 1'b0;
      err_ovr     <= 1'b0;
    end else begin
      sec_done <= 1'b0;

      if (fill_we) begin
        fill_ptr <= fill_ptr + 1'b1;
        if (fill_last) begin
          full[fill_bank] <= 1'b1;
          fill_bank       <= !fill_bank;
        end
      end

      case (state)
        ST_IDLE: begin
          if (full[drain_bank] && !all_done) state <= ST_START;
        end
        // Hold the start level until the writer reports busy.
        ST_START: begin
          if (wr_busy) begin
            wr_start_en <= 1'b0;
            rd_cnt      <= '0;
            state       <= ST_XFER;
          end else begin
            wr_start_en <= 1'b1;
          end
        end
        ST_XFER: begin
          if (wr_req && rd_spent) err_ovr <= 1'b1;
          else if (rd_en)         rd_cnt  <= rd_cnt + 1'b1;
          if (rd_spent) state <= ST_WAIT_END;
        end
        ST_WAIT_END: begin
          if (wr_req) err_ovr <= 1'b1;
          if (!wr_busy) begin
            full[drain_bank] <= 1'b0;
            drain_bank       <= !drain_bank;
            wr_sec_addr      <= wr_sec_addr + 32'd1;
            sec_done         <= 1'b1;
            sec_cnt          <= sec_cnt + 32'd1;
            if ((SECTOR_COUNT != '0) && (sec_cnt + 32'd1 == SECTOR_COUNT))
              all_done <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sd_bank_ram u_ram (
    .clk_ref (clk_ref),
    .rst     (rst),
    .we      (fill_we),
    .wr      (fill_wr),
    .re      (rd_en),
    .raddr   ({drain_bank, rd_cnt[PTR_W-1:0]}),
    .rdata   (wr_data)
  );

endmodule

// File: tb/tb_sd_wr_feeder.sv
// Randomized bench for sd_wr_feeder: upstream source and SD writer models
// with a word-queue / sector-count reference checked every cycle.
module tb_sd_wr_feeder;

  localparam logic [31:0] START = 32'hFFFF_FFFE;
  localparam logic [31:0] SCNT  = 32'd4;

  logic        clk_ref = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        wr_start_en;
  logic [31:0] wr_sec_addr;
  logic [15:0] wr_data;
  logic        wr_req = 1'b0;
  logic        wr_busy = 1'b0;
  logic        sec_done;
  logic        all_done;
  logic        err_ovr;

  sd_wr_feeder #(.START_SECTOR(START), .SECTOR_COUNT(SCNT)) dut (
    .clk_ref     (clk_ref),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .wr_start_en (wr_start_en),
    .wr_sec_addr (wr_sec_addr),
    .wr_data     (wr_data),
    .wr_req      (wr_req),
    .wr_busy     (wr_busy),
    .sec_done    (sec_done),
    .all_done    (all_done),
    .err_ovr     (err_ovr)
  );

  always #5 clk_ref = ~clk_ref;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          acc, done_cnt, served, issued;
  logic [15:0] exp_q[$];
  logic [15:0] last_data;
  bit          exp_err, req_pend, drop_pend, in_ready_seen, saw_full;
  logic [15:0] rx_first, rx_last;
  // Writer model: 0 idle, 1 awaiting start, 2 busy raised, 3 serving, 4 tail
  int          wph, wcnt, bdly, gcnt, tail;
  // Configuration of the current phase
  int          gap_max, src_left;
  bit          do_ovr, src_inc;
  logic [15:0] src_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    int held;
    bit adone, exp_sd, exp_st;
    @(negedge clk_ref);
    exp_sd = 1'b0;
    if (rst) begin
      acc = 0; done_cnt = 0; served = 0; issued = 0;
      exp_q.delete(); last_data = '0; exp_err = 0;
      req_pend = 0; drop_pend = 0; wph = 0;
    end else begin
      if (in_valid && in_ready_seen) begin
        acc++;
        exp_q.push_back(in_data);
        src_left--;
        src_word = src_inc ? src_word + 16'd1 : 16'($urandom);
      end
      if (drop_pend) begin
        done_cnt++;
        exp_sd = 1'b1;
        drop_pend = 0;
      end
      if (req_pend) begin
        req_pend = 0;
        if (served < 256) begin
          if (exp_q.size() > 0) last_data = exp_q.pop_front();
          served++;
          if (served == 1) rx_first = wr_data;
          rx_last = wr_data;
        end else begin
          exp_err = 1'b1;
        end
      end
    end

    held  = acc - 256 * done_cnt;
    adone = (SCNT != 0) && (32'(done_cnt) == SCNT);
    if (!rst && wph == 0 && held >= 256 && !adone) begin
      wph = 1; wcnt = 0; bdly = $urandom_range(0, 3);
    end
    exp_st = (wph == 1) && (wcnt >= 2);

    chk("in_ready",    32'(in_ready),    32'(!rst && held < 512 && !adone));
    chk("wr_start_en", 32'(wr_start_en), 32'(exp_st));
    chk("wr_sec_addr", wr_sec_addr,      START + 32'(done_cnt));
    chk("wr_data",     32'(wr_data),     32'(last_data));
    chk("sec_done",    32'(sec_done),    32'(exp_sd));
    chk("all_done",    32'(all_done),    32'(adone));
    chk("err_ovr",     32'(err_ovr),     32'(exp_err));
    if (held >= 512 && !in_ready) saw_full = 1'b1;
    in_ready_seen = in_ready;

    if (rst) begin
      in_valid = 0; wr_req = 0; wr_busy = 0;
    end else begin
      case (wph)
        1: if (wcnt >= 2 + bdly) begin wr_busy = 1; wph = 2; end
           else wcnt++;
        2: begin wph = 3; served = 0; issued = 0; gcnt = 0; end
        3: if (wr_req) wr_req = 0;
           else if (issued < (do_ovr ? 257 : 256)) begin
             if (gcnt == 0) begin
               wr_req = 1; issued++; req_pend = 1;
               gcnt = $urandom_range(0, gap_max);
             end else gcnt--;
           end else begin
             wph = 4; tail = 3 + $urandom_range(0, 5);
           end
        4: if (tail == 0) begin wr_busy = 0; drop_pend = 1; wph = 0; end
           else tail--;
        default: ;
      endcase
      if (src_left > 0) begin in_valid = 1; in_data = src_word; end
      else in_valid = 0;
    end
  endtask

  task automatic run_until_done(input int n, input int limit);
    int t = 0;
    while (done_cnt < n && t < limit) begin step(); t++; end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1; src_left = 0; in_valid = 0; wr_req = 0; wr_busy = 0;
    repeat (cycles) step();
    rst = 0;
  endtask

  initial begin
    src_left = 0; src_inc = 1; src_word = '0; gap_max = 1; do_ovr = 0;
    saw_full = 0; rx_first = 'x; rx_last = 'x; in_ready_seen = 0;

    repeat (3) step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_addr",     wr_sec_addr,   32'hFFFF_FFFE);
    chk("rst_start",    32'(wr_start_en), 32'd0);
    chk("rst_wr_data",  32'(wr_data),  32'd0);
    rst = 0;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // One sector of 0x0000..0x00FF, fast writer
    src_inc = 1; src_word = 16'h0000; src_left = 256; gap_max = 1;
    run_until_done(1, 4000);
    chk("p1_done",  32'(done_cnt), 32'd1);
    chk("p1_first", 32'(rx_first), 32'h0000);
    chk("p1_last",  32'(rx_last),  32'h00FF);
    chk("p1_addr",  wr_sec_addr,   32'hFFFF_FFFF);

    // Continuous random stream, slow writer, sector limit reached
    src_inc = 0; src_word = 16'($urandom); src_left = 1000; gap_max = 6;
    run_until_done(4, 20000);
    chk("p2_done",     32'(done_cnt), 32'd4);
    chk("p2_all_done", 32'(all_done), 32'd1);
    chk("p2_addr",     wr_sec_addr,   32'h0000_0002);
    repeat (300) step();
    chk("p2_no_start",     32'(wr_start_en), 32'd0);
    chk("p2_in_ready",     32'(in_ready),    32'd0);
    chk("p2_backpressure", 32'(saw_full),    32'd1);

    // Overrun request on a fresh run
    do_reset(2);
    src_inc = 1; src_word = 16'h0100; src_left = 256; gap_max = 2; do_ovr = 1;
    run_until_done(1, 4000);
    chk("p3_done", 32'(done_cnt), 32'd1);
    chk("p3_err",  32'(err_ovr),  32'd1);
    chk("p3_last", 32'(rx_last),  32'h01FF);
    chk("p3_addr", wr_sec_addr,   32'hFFFF_FFFF);

    // Reset in the middle of serving a sector
    do_ovr = 0; src_word = 16'h1000; src_left = 256;
    begin
      int t = 0;
      while (!(wph == 3 && served >= 100) && t < 4000) begin step(); t++; end
    end
    chk("p4_served", 32'(served), 32'd100);
    rst = 1; src_left = 0; in_valid = 0; wr_req = 0; wr_busy = 0;
    step();
    chk("p4_rst_start",    32'(wr_start_en), 32'd0);
    chk("p4_rst_wr_data",  32'(wr_data),     32'd0);
    chk("p4_rst_err",      32'(err_ovr),     32'd0);
    chk("p4_rst_sec_done", 32'(sec_done),    32'd0);
    chk("p4_rst_addr",     wr_sec_addr,      32'hFFFF_FFFE);
    chk("p4_rst_in_ready", 32'(in_ready),    32'd0);
    rst = 0;

    src_word = 16'h2000; src_left = 256; gap_max = 1;
    run_until_done(1, 4000);
    chk("p5_done",  32'(done_cnt), 32'd1);
    chk("p5_first", 32'(rx_first), 32'h2000);
    chk("p5_last",  32'(rx_last),  32'h20FF);
    chk("p5_addr",  wr_sec_addr,   32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
